syndrome_sched: RTL and testbench

Round-robin scheduler and sequencer for the 15-bit folding syndrome register. It accepts N-bit codewords from two requesters over valid/ready, serialises each one MSB-first through the feedback register for a fixed number of shift cycles, and returns the 15-bit syndrome, a zero flag and the source ID over a result handshake. The block sits between the codeword producers and the decision logic downstream and owns the single syndrome datapath.

---
 rtl/syndrome_pkg.sv | 21 ++
 rtl/syndrome_shift.sv | 52 +++++
 rtl/syndrome_sched.sv | 137 +++++++++++++
 tb/tb_syndrome_sched.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/syndrome_pkg.sv
// Shared types and constants for the syndrome scheduler and its shift datapath.
// syn_step is the single definition of one feedback-register shift.
package syndrome_pkg;

   localparam int SYN_W = 15;
   localparam int CNT_W = 11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      RESULT = 2'd2
   } state_e;

   typedef logic src_t;

   function automatic logic [SYN_W-1:0] syn_step(input logic [SYN_W-1:0] r,
                                                 input logic             b);
      return {b ^ r[0], r[SYN_W-1:1]};
   endfunction

endpackage

// File: rtl/syndrome_shift.sv
// 15-bit folding syndrome register with its 11-bit shift counter.
// Feeds the codeword MSB-first; positions at or beyond N feed zero.
module syndrome_shift
   import syndrome_pkg::*;
#(
   parameter int N = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             shift,
   input  logic [N-1:0]     data,
   output logic [SYN_W-1:0] r,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [N-1:0] MSB = {1'b1, {(N-1){1'b0}}};

   logic [SYN_W-1:0] r_q, r_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     sel_mask;
   logic             in_bit;

   // The mask walks off the bottom once cnt >= N, which injects zeros.
   always_comb begin
      sel_mask = MSB >> cnt_q;
      in_bit   = |(data & sel_mask);
      r_d      = r_q;
      cnt_d    = cnt_q;
      if (clear) begin
         r_d   = '0;
         cnt_d = '0;
      end else if (shift) begin
         r_d   = syn_step(r_q, in_bit);
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q   <= '0;
         cnt_q <= '0;
      end else begin
         r_q   <= r_d;
         cnt_q <= cnt_d;
      end
   end

   assign r   = r_q;
   assign cnt = cnt_q;

endmodule

// File: rtl/syndrome_sched.sv
// Round-robin front end and job sequencer for the shared syndrome datapath:
// accepts a codeword, shifts it SHIFTS times, then presents the result.
module syndrome_sched
   import syndrome_pkg::*;
#(
   parameter int N      = 64,
   parameter int SHIFTS = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [N-1:0]     req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [N-1:0]     req1_data,
   output logic             req1_ready,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [SYN_W-1:0] res_syndrome,
   output logic             res_zero,
   output logic             res_src,
   output logic             busy,
   output state_e           dbg_state
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SHIFTS - 1);
   localparam logic [N-1:0]     MSB      = {1'b1, {(N-1){1'b0}}};

   state_e           state_q, state_d;
   logic [N-1:0]     data_q, data_d;
   src_t             src_q, src_d;
   src_t             last_q, last_d;
   src_t             grant;
   logic [SYN_W-1:0] res_syn_q, res_syn_d;
   logic             res_zero_q, res_zero_d;
   src_t             res_src_q, res_src_d;
   logic             clear, shift_en;
   logic [SYN_W-1:0] r;
   logic [CNT_W-1:0] cnt;
   logic [N-1:0]     sel_mask;
   logic [SYN_W-1:0] final_syn;

   syndrome_shift #(.N(N)) u_shift (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .shift (shift_en),
      .data  (data_q),
      .r     (r),
      .cnt   (cnt)
   );

   // The last shift is evaluated here too, so the result and its zero flag
   // are registered on the same edge the register takes its final value.
   always_comb begin
      sel_mask  = MSB >> cnt;
      final_syn = syn_step(r, |(data_q & sel_mask));
   end

   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // Request readies depend only on the request valids and the state;
   // res_valid is a pure state decode, and res_ready only moves the FSM.
   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      src_d      = src_q;
      last_d     = last_q;
      res_syn_d  = res_syn_q;
      res_zero_d = res_zero_q;
      res_src_d  = res_src_q;
      clear      = 1'b0;
      shift_en   = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      grant      = (req0_valid && req1_valid) ? ~last_q : req1_valid;

      case (state_q)
         IDLE: begin
            req0_ready = req0_valid && !grant;
            req1_ready = req1_valid && grant;
            if (req0_ready || req1_ready) begin
               data_d  = grant ? req1_data : req0_data;
               src_d   = grant;
               last_d  = grant;
               clear   = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (cnt == LAST_CNT) begin
               res_syn_d  = final_syn;
               res_zero_d = (final_syn == '0);
               res_src_d  = src_q;
               state_d    = RESULT;
            end
         end
         RESULT: begin
            if (res_ready) begin
               res_syn_d  = '0;
               res_zero_d = 1'b0;
               res_src_d  = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         data_q     <= '0;
         src_q      <= 1'b0;
         last_q     <= 1'b1;
         res_syn_q  <= '0;
         res_zero_q <= 1'b0;
         res_src_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         src_q      <= src_d;
         last_q     <= last_d;
         res_syn_q  <= res_syn_d;
         res_zero_q <= res_zero_d;
         res_src_q  <= res_src_d;
      end
   end

   assign res_valid    = (state_q == RESULT);
   assign res_syndrome = res_syn_q;
   assign res_zero     = res_zero_q;
   assign res_src      = res_src_q;
   assign busy         = (state_q != IDLE);
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_syndrome_sched.sv
// Directed bench for syndrome_sched: arbitration, latency, result contents,
// backpressure and mid-job reset, checked against a cyclic-position model.
module tb_syndrome_sched;
   import syndrome_pkg::*;

   localparam int N      = 64;
   localparam int SHIFTS = 64;
   localparam int W      = 17;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic [N-1:0]  req0_data = '0, req1_data = '0;
   logic          req0_ready, req1_ready;
   logic          res_valid, res_zero, res_src, busy;
   logic          res_ready = 1'b1;
   logic [14:0]   res_syndrome;
   state_e        dbg_state;

   syndrome_sched #(.N(N), .SHIFTS(SHIFTS)) dut (
      .clk          (clk),
      .rst          (rst),
      .req0_valid   (req0_valid),
      .req0_data    (req0_data),
      .req0_ready   (req0_ready),
      .req1_valid   (req1_valid),
      .req1_data    (req1_data),
      .req1_ready   (req1_ready),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_syndrome (res_syndrome),
      .res_zero     (res_zero),
      .res_src      (res_src),
      .busy         (busy),
      .dbg_state    (dbg_state)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   // Bit at shift c enters the top of a 15-bit ring and rotates right once
   // per remaining shift, so it lands at 14 - ((SHIFTS-1-c) mod 15).
   function automatic logic [14:0] mdl_syn(input logic [N-1:0] d);
      logic [14:0] s;
      s = '0;
      for (int c = 0; c < SHIFTS; c++) begin
         if (c < N && d[N-1-c])
            s = s ^ (15'(1) << (14 - ((SHIFTS - 1 - c) % 15)));
      end
      return s;
   endfunction

   logic [W-1:0] exp_q[$];
   int           m_phase = 0;   // 0 waiting for a job, 1 job running, 2 result pending
   int           m_left  = 0;
   logic         m_last  = 1'b1;
   logic         m_g, m_e0, m_e1;
   logic [N-1:0] m_d;
   logic [14:0]  m_s;
   logic [W-1:0] m_e;

   int   acc_src[$];
   int   acc_cyc[$];

   // ---------------- scoreboard / compare ----------------
   always @(negedge clk) begin
      if (rst) begin
         m_phase = 0;
         m_last  = 1'b1;
         exp_q.delete();
         chk("rst_res_valid", res_valid, 0);
         chk("rst_res_syndrome", res_syndrome, 0);
         chk("rst_res_zero", res_zero, 0);
         chk("rst_res_src", res_src, 0);
         chk("rst_busy", busy, 0);
         chk("rst_req0_ready", req0_ready, req0_valid && !req1_valid);
         chk("rst_req1_ready", req1_ready, 0);
      end else begin
         m_g  = (req0_valid && req1_valid) ? ~m_last : req1_valid;
         m_e0 = (m_phase == 0) && req0_valid && !m_g;
         m_e1 = (m_phase == 0) && req1_valid && m_g;
         chk("req0_ready", req0_ready, m_e0);
         chk("req1_ready", req1_ready, m_e1);
         chk("busy", busy, m_phase != 0);
         chk("res_valid", res_valid, m_phase == 2);
         if (m_phase == 2 && exp_q.size() > 0) begin
            m_e = exp_q[0];
            chk("res_syndrome", res_syndrome, m_e[14:0]);
            chk("res_zero", res_zero, m_e[15]);
            chk("res_src", res_src, m_e[16]);
         end
         if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
            acc_src.push_back(req1_ready ? 1 : 0);
            acc_cyc.push_back(cyc + 1);
         end
         case (m_phase)
            0: if (m_e0 || m_e1) begin
                  m_d = m_g ? req1_data : req0_data;
                  m_s = mdl_syn(m_d);
                  exp_q.push_back({m_g, (m_s == 15'd0), m_s});
                  m_last  = m_g;
                  m_phase = 1;
                  m_left  = SHIFTS;
               end
            1: begin
                  m_left--;
                  if (m_left == 0) m_phase = 2;
               end
            default: if (res_ready) begin
                  void'(exp_q.pop_front());
                  m_phase = 0;
               end
         endcase
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_req(input int p, input logic v, input logic [N-1:0] d);
      if (p == 0) begin
         req0_valid = v;
         req0_data  = d;
      end else begin
         req1_valid = v;
         req1_data  = d;
      end
   endtask

   // Returns once the accepted job's result is visible (posedge + 1).
   task automatic run_job(input int p, input logic [N-1:0] d,
                          output logic [14:0] syn, output logic z,
                          output logic s, output int lat);
      int n0, k, t0;
      n0  = acc_src.size();
      syn = '0;
      z   = 1'b0;
      s   = 1'b0;
      lat = -1;
      @(posedge clk); #1;
      set_req(p, 1'b1, d);
      k = 0;
      while (acc_src.size() == n0 && k < 300) begin
         @(posedge clk); #1;
         k++;
      end
      set_req(p, 1'b0, '0);
      if (k >= 300) begin
         chk("accept_timeout", 1, 0);
         return;
      end
      t0 = cyc;
      k  = 0;
      while (!res_valid && k < 300) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 300) begin
         chk("result_timeout", 1, 0);
         return;
      end
      lat = cyc - t0;
      syn = res_syndrome;
      z   = res_zero;
      s   = res_src;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((busy || exp_q.size() != 0) && k < 500) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 500) chk("idle_timeout", 1, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic [14:0] syn;
      logic        z, s;
      int          lat, base, k, c0;
      logic [N-1:0] one;

      one = 64'h1;

      chk("pin_zero", mdl_syn('0), 15'h0000);
      chk("pin_bit63", mdl_syn(one << 63), 15'h0800);
      chk("pin_bit0", mdl_syn(one), 15'h4000);
      chk("pin_bit0_15", mdl_syn(one | (one << 15)), 15'h0000);
      chk("pin_all_ones", mdl_syn('1), 15'h7800);

      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // 1: all-zero codeword, latency
      run_job(0, '0, syn, z, s, lat);
      chk("t1_syn", syn, 15'h0000);
      chk("t1_zero", z, 1);
      chk("t1_src", s, 0);
      chk("t1_latency", lat, SHIFTS);

      // 2a: first bit shifted
      run_job(0, one << 63, syn, z, s, lat);
      chk("t2a_syn", syn, 15'h0800);
      chk("t2a_zero", z, 0);

      // 3: bits 0 and 15 cancel
      run_job(0, one | (one << 15), syn, z, s, lat);
      chk("t3_syn", syn, 15'h0000);
      chk("t3_zero", z, 1);

      // extra patterns, model only
      run_job(1, 64'hDEAD_BEEF_0123_4567, syn, z, s, lat);
      chk("tx_src", s, 1);
      run_job(0, '1, syn, z, s, lat);
      chk("tx_all_ones", syn, 15'h7800);

      // 2b: last bit shifted, from req1 so req1 is last served before the ties
      run_job(1, one, syn, z, s, lat);
      chk("t2b_syn", syn, 15'h4000);
      chk("t2b_src", s, 1);
      wait_idle();

      // 4: continuous tie, alternating grants 66 cycles apart
      base = acc_src.size();
      @(posedge clk); #1;
      set_req(0, 1'b1, 64'h0123_4567_89AB_CDEF);
      set_req(1, 1'b1, 64'hFEDC_BA98_7654_3210);
      k = 0;
      while (acc_src.size() < base + 4 && k < 400) begin
         @(posedge clk); #1;
         k++;
      end
      set_req(0, 1'b0, '0);
      set_req(1, 1'b0, '0);
      if (k >= 400) chk("t4_timeout", 1, 0);
      else begin
         for (int i = 0; i < 4; i++) chk("t4_grant_order", acc_src[base+i], i % 2);
         for (int i = 1; i < 4; i++)
            chk("t4_spacing", acc_cyc[base+i] - acc_cyc[base+i-1], SHIFTS + 2);
      end
      wait_idle();

      // 5: backpressure for 10 cycles, pending req1 must wait
      res_ready = 1'b0;
      run_job(0, one << 63, syn, z, s, lat);
      set_req(1, 1'b1, one);
      base = acc_src.size();
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("t5_valid_held", res_valid, 1);
         chk("t5_syn_held", res_syndrome, 15'h0800);
         chk("t5_src_held", res_src, 0);
         chk("t5_req1_ready_low", req1_ready, 0);
      end
      res_ready = 1'b1;
      c0 = cyc;
      k  = 0;
      while (acc_src.size() == base && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      set_req(1, 1'b0, '0);
      if (k >= 20) chk("t5_accept_timeout", 1, 0);
      else begin
         chk("t5_accept_gap", cyc - c0, 2);
         chk("t5_accept_src", acc_src[base], 1);
      end
      wait_idle();

      // 6: reset 30 shifts into a job
      base = acc_src.size();
      @(posedge clk); #1;
      set_req(0, 1'b1, 64'hFFFF_0000_AAAA_5555);
      k = 0;
      while (acc_src.size() == base && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      set_req(0, 1'b0, '0);
      if (k >= 20) chk("t6_accept_timeout", 1, 0);
      repeat (30) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_res_valid", res_valid, 0);
      chk("t6_res_syndrome", res_syndrome, 0);
      chk("t6_res_zero", res_zero, 0);
      chk("t6_res_src", res_src, 0);
      @(posedge clk); #1 rst = 1'b0;

      base = acc_src.size();
      set_req(0, 1'b1, one << 63);
      set_req(1, 1'b1, one);
      k = 0;
      while (acc_src.size() == base && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      set_req(0, 1'b0, '0);
      if (k >= 20) chk("t6_tie_timeout", 1, 0);
      else chk("t6_tie_winner", acc_src[base], 0);
      k = 0;
      while (!res_valid && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      chk("t6_result_seen", res_valid, 1);
      chk("t6_syn", res_syndrome, 15'h0800);
      chk("t6_src", res_src, 0);
      k = 0;
      while (acc_src.size() == base + 1 && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      set_req(1, 1'b0, '0);
      if (k >= 20) chk("t6_held_timeout", 1, 0);
      else chk("t6_held_winner", acc_src[base+1], 1);
      wait_idle();

      repeat (4) @(posedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
